// File: rtl/issue_scheduler_if.sv
// Fetch-to-decode bundle of the instruction issue scheduler: fetched groups in,
// queue head pair plus hazard/stall/flush controls and issue statistics.
interface issue_scheduler_if;
    logic        FetchValid;
    logic [1:0]  FetchCount;
    logic [31:0] InstrFA;
    logic [31:0] PCPlus4FA;
    logic [31:0] InstrFB;
    logic [31:0] PCPlus4FB;
    logic        FetchReady;
    logic [31:0] InstrA;
    logic [31:0] PCPlus4A;
    logic [31:0] InstrB;
    logic [31:0] PCPlus4B;
    logic        ValidA;
    logic        ValidB;
    logic        PairOK;
    logic        StallD;
    logic        FlushD;
    logic [31:0] DualIssues;
    logic [31:0] SingleIssues;

    modport master (
        output FetchValid, FetchCount, InstrFA, PCPlus4FA, InstrFB, PCPlus4FB,
        output PairOK, StallD, FlushD,
        input  FetchReady, InstrA, PCPlus4A, InstrB, PCPlus4B, ValidA, ValidB,
        input  DualIssues, SingleIssues
    );

    modport slave (
        input  FetchValid, FetchCount, InstrFA, PCPlus4FA, InstrFB, PCPlus4FB,
        input  PairOK, StallD, FlushD,
        output FetchReady, InstrA, PCPlus4A, InstrB, PCPlus4B, ValidA, ValidB,
        output DualIssues, SingleIssues
    );
endinterface

// File: rtl/issue_scheduler.sv
// Dual-issue instruction queue between fetch and decode: buffers fetched pairs,
// presents head/head+1 to decode and pops one or two entries per cycle.
module issue_scheduler #(
    parameter int DEPTH  = 4,
    parameter int STAT_W = 32
) (
    input logic              clk,
    input logic              rst_n,
    issue_scheduler_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       instr_mem [DEPTH];
    logic [31:0]       pc4_mem   [DEPTH];
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [AW-1:0]     head_b;
    logic [AW-1:0]     tail_b;
    logic [CW-1:0]     count;
    logic [STAT_W-1:0] dual_cnt;
    logic [STAT_W-1:0] single_cnt;
    logic [1:0]        push_n;
    logic [1:0]        pop_n;
    logic              fetch_ready;
    logic              valid_a;
    logic              valid_b;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.FlushD)          state_nxt = DRAIN;
        else if (state == DRAIN) state_nxt = RUN;
    end

    // NOTE: defaults first in every always_comb, so no path can infer a latch.
    always_comb begin
        fetch_ready = 1'b0;
        valid_a     = 1'b0;
        valid_b     = 1'b0;
        if (state == RUN) begin
            fetch_ready = (CW'(DEPTH) - count) >= CW'(2);
            valid_a     = (count != '0) && !bus.StallD && !bus.FlushD;
            valid_b     = valid_a && (count >= CW'(2)) && bus.PairOK;
        end
    end

    // Only group sizes 1 and 2 are real pushes; fetch_ready is already low in DRAIN.
    always_comb begin
        push_n = 2'd0;
        if (bus.FetchValid && fetch_ready && !bus.FlushD) begin
            if (bus.FetchCount == 2'd1)      push_n = 2'd1;
            else if (bus.FetchCount == 2'd2) push_n = 2'd2;
        end
    end

    assign pop_n  = {1'b0, valid_a} + {1'b0, valid_b};
    assign head_b = head + AW'(1);
    assign tail_b = tail + AW'(1);

    // NOTE: storage is not reset; count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push_n != 2'd0) begin
            instr_mem[tail] <= bus.InstrFA;
            pc4_mem[tail]   <= bus.PCPlus4FA;
        end
        if (push_n == 2'd2) begin
            instr_mem[tail_b] <= bus.InstrFB;
            pc4_mem[tail_b]   <= bus.PCPlus4FB;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.FlushD) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(pop_n);
            tail  <= tail + AW'(push_n);
            count <= count + CW'(push_n) - CW'(pop_n);
        end
    end

    // Statistics survive flushes and saturate instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dual_cnt   <= '0;
            single_cnt <= '0;
        end else begin
            if (valid_b && dual_cnt != '1)
                dual_cnt <= dual_cnt + STAT_W'(1);
            if (valid_a && !valid_b && single_cnt != '1)
                single_cnt <= single_cnt + STAT_W'(1);
        end
    end

    assign bus.FetchReady   = fetch_ready;
    assign bus.ValidA       = valid_a;
    assign bus.ValidB       = valid_b;
    assign bus.DualIssues   = 32'(dual_cnt);
    assign bus.SingleIssues = 32'(single_cnt);

    always_comb begin
        bus.InstrA   = '0;
        bus.PCPlus4A = '0;
        bus.InstrB   = '0;
        bus.PCPlus4B = '0;
        if (count != '0) begin
            bus.InstrA   = instr_mem[head];
            bus.PCPlus4A = pc4_mem[head];
        end
        if (count >= CW'(2)) begin
            bus.InstrB   = instr_mem[head_b];
            bus.PCPlus4B = pc4_mem[head_b];
        end
    end
endmodule

// File: tb/tb_issue_scheduler.sv
// Scoreboard bench for issue_scheduler: fetched instructions queue up as expected
// issues, a negedge monitor pops them whenever a decode slot issues.
module tb_issue_scheduler;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    entry_t exp_q [$];
    int     n_cmp  = 0;
    int     n_fail = 0;
    int     seq    = 0;

    always #5 clk = ~clk;

    issue_scheduler_if bus ();
    issue_scheduler_if sbus ();

    issue_scheduler #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    issue_scheduler #(.DEPTH(DEPTH), .STAT_W(4)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic pop_check(input string slot, input logic [31:0] instr, input logic [31:0] pc4);
        entry_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_unexpected: issued 0x%08h, nothing expected", slot, instr);
        end else begin
            e = exp_q.pop_front();
            check({slot, "_instr"}, instr, e.instr);
            check({slot, "_pc4"}, pc4, e.pc4);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ValidA) pop_check("issue_a", bus.InstrA, bus.PCPlus4A);
            if (bus.ValidB) pop_check("issue_b", bus.InstrB, bus.PCPlus4B);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.FetchValid = 1'b0;
        bus.FetchCount = 2'd0;
        bus.InstrFA    = '0;
        bus.PCPlus4FA  = '0;
        bus.InstrFB    = '0;
        bus.PCPlus4FB  = '0;
        bus.PairOK     = 1'b0;
        bus.StallD     = 1'b0;
        bus.FlushD     = 1'b0;
    endtask

    task automatic sidle();
        sbus.FetchValid = 1'b0;
        sbus.FetchCount = 2'd0;
        sbus.InstrFA    = '0;
        sbus.PCPlus4FA  = '0;
        sbus.InstrFB    = '0;
        sbus.PCPlus4FB  = '0;
        sbus.PairOK     = 1'b0;
        sbus.StallD     = 1'b0;
        sbus.FlushD     = 1'b0;
    endtask

    // accept is the hand-derived verdict on whether the DUT takes this group.
    task automatic fetch(input int n, input logic [31:0] ia, input logic [31:0] pa,
                         input logic [31:0] ib, input logic [31:0] pb, input bit accept);
        bus.FetchValid = 1'b1;
        bus.FetchCount = 2'(n);
        bus.InstrFA    = ia;
        bus.PCPlus4FA  = pa;
        bus.InstrFB    = ib;
        bus.PCPlus4FB  = pb;
        if (accept) begin
            exp_q.push_back('{instr: ia, pc4: pa});
            if (n == 2) exp_q.push_back('{instr: ib, pc4: pb});
        end
    endtask

    task automatic fetch_seq(input int n, input bit accept);
        fetch(n, 32'h1000_0000 + 32'(seq), 32'h0000_1000 + 32'(4 * seq),
                 32'h1000_0001 + 32'(seq), 32'h0000_1004 + 32'(4 * seq), accept);
        seq += 2;
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        idle();
        sidle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check1("rst_valid_a", bus.ValidA, 1'b0);
        check1("rst_valid_b", bus.ValidB, 1'b0);
        check1("rst_fetch_ready", bus.FetchReady, 1'b1);
        check("rst_instr_a", bus.InstrA, 32'h0);
        check("rst_pc4_a", bus.PCPlus4A, 32'h0);
        check("rst_instr_b", bus.InstrB, 32'h0);
        check("rst_pc4_b", bus.PCPlus4B, 32'h0);
        check("rst_dual", bus.DualIssues, 32'd0);
        check("rst_single", bus.SingleIssues, 32'd0);
        tick();

        // Pair with dual-issue permission
        idle(); fetch(2, 32'h0022_1820, 32'd4, 32'h0085_2020, 32'd8, 1'b1); bus.PairOK = 1'b1; #1;
        check1("pair_ready", bus.FetchReady, 1'b1);
        check1("pair_no_bypass", bus.ValidA, 1'b0);
        tick();
        idle(); bus.PairOK = 1'b1; #1;
        check1("pair_valid_a", bus.ValidA, 1'b1);
        check1("pair_valid_b", bus.ValidB, 1'b1);
        tick();
        idle(); #1;
        check1("pair_empty", bus.ValidA, 1'b0);
        check("pair_dual", bus.DualIssues, 32'd1);
        check("pair_single", bus.SingleIssues, 32'd0);
        tick();

        // Same pair, no dual-issue permission
        idle(); fetch(2, 32'h0022_1820, 32'd4, 32'h0085_2020, 32'd8, 1'b1); #1;
        tick();
        idle(); #1;
        check1("split_c1_a", bus.ValidA, 1'b1);
        check1("split_c1_b", bus.ValidB, 1'b0);
        check("split_c1_instr_b", bus.InstrB, 32'h0085_2020);
        tick();
        idle(); #1;
        check1("split_c2_a", bus.ValidA, 1'b1);
        check1("split_c2_b", bus.ValidB, 1'b0);
        check("split_c2_instr_a", bus.InstrA, 32'h0085_2020);
        check("split_c2_single", bus.SingleIssues, 32'd1);
        tick();
        idle(); #1;
        check1("split_empty", bus.ValidA, 1'b0);
        check("split_single", bus.SingleIssues, 32'd2);
        check("split_dual", bus.DualIssues, 32'd1);
        tick();

        // Stall while fetch keeps pushing pairs: fills to DEPTH
        idle(); bus.StallD = 1'b1; fetch_seq(2, 1'b1); #1;
        check1("stall1_ready", bus.FetchReady, 1'b1);
        tick();
        idle(); bus.StallD = 1'b1; fetch_seq(2, 1'b1); #1;
        check1("stall2_ready", bus.FetchReady, 1'b1);
        check1("stall2_hold", bus.ValidA, 1'b0);
        tick();
        idle(); bus.StallD = 1'b1; fetch_seq(2, 1'b0); #1;
        check1("stall3_full", bus.FetchReady, 1'b0);
        check1("stall3_hold", bus.ValidA, 1'b0);
        tick();
        idle(); bus.PairOK = 1'b1; #1;
        check("stall_dual_kept", bus.DualIssues, 32'd1);
        check("stall_single_kept", bus.SingleIssues, 32'd2);
        check1("resume1_a", bus.ValidA, 1'b1);
        check1("resume1_b", bus.ValidB, 1'b1);
        check1("resume1_no_credit", bus.FetchReady, 1'b0);
        tick();
        idle(); bus.PairOK = 1'b1; #1;
        check1("resume2_b", bus.ValidB, 1'b1);
        check1("resume2_ready", bus.FetchReady, 1'b1);
        tick();
        idle(); #1;
        check1("resume_empty", bus.ValidA, 1'b0);
        check("resume_dual", bus.DualIssues, 32'd3);
        tick();

        // Flush with three queued entries and a fetch presented
        idle(); bus.StallD = 1'b1; fetch_seq(2, 1'b1); #1;
        tick();
        idle(); bus.StallD = 1'b1; fetch_seq(1, 1'b1); #1;
        check1("fill3_ready", bus.FetchReady, 1'b1);
        tick();
        idle(); bus.FlushD = 1'b1; bus.StallD = 1'b1; fetch_seq(2, 1'b0); #1;
        check1("flush_ready_cnt3", bus.FetchReady, 1'b0);
        check1("flush_no_issue", bus.ValidA, 1'b0);
        tick();
        exp_q.delete();
        idle(); fetch_seq(2, 1'b0); #1;
        check1("drain_ready", bus.FetchReady, 1'b0);
        check1("drain_valid_a", bus.ValidA, 1'b0);
        check("drain_instr_a", bus.InstrA, 32'h0);
        tick();
        idle(); #1;
        check1("run_ready", bus.FetchReady, 1'b1);
        check1("run_empty", bus.ValidA, 1'b0);
        tick();

        // Flush while already draining extends DRAIN by a cycle
        idle(); bus.FlushD = 1'b1; fetch_seq(2, 1'b0); #1;
        check1("x1_ready", bus.FetchReady, 1'b1);
        tick();
        idle(); bus.FlushD = 1'b1; #1;
        check1("x2_ready", bus.FetchReady, 1'b0);
        tick();
        idle(); fetch_seq(2, 1'b0); #1;
        check1("x3_drain_held", bus.FetchReady, 1'b0);
        tick();
        idle(); #1;
        check1("x4_ready", bus.FetchReady, 1'b1);
        check1("x4_fetch_ignored", bus.ValidA, 1'b0);
        check("flush_keeps_dual", bus.DualIssues, 32'd3);
        check("flush_keeps_single", bus.SingleIssues, 32'd2);
        tick();

        // Single-instruction stream across pointer wrap, PairOK toggling
        for (int i = 0; i < 14; i++) begin
            idle();
            bus.StallD = (i % 3 == 0);
            bus.PairOK = (i % 2 == 1);
            fetch_seq(1, 1'b1);
            #1;
            check1("stream_ready", bus.FetchReady, 1'b1);
            tick();
        end
        idle(); bus.PairOK = 1'b1;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick();
        check("stream_drained", 32'(exp_q.size()), 32'd0);
        idle(); #1;
        tick();

        // Reset in the middle of operation overrides everything
        idle(); fetch_seq(2, 1'b1); #1;
        tick();
        idle(); rst_n = 1'b0; bus.PairOK = 1'b1; fetch_seq(2, 1'b0); #1;
        tick();
        exp_q.delete();
        rst_n = 1'b1;
        idle(); #1;
        check1("mid_rst_valid_a", bus.ValidA, 1'b0);
        check1("mid_rst_ready", bus.FetchReady, 1'b1);
        check("mid_rst_instr_a", bus.InstrA, 32'h0);
        check("mid_rst_dual", bus.DualIssues, 32'd0);
        check("mid_rst_single", bus.SingleIssues, 32'd0);
        tick();

        // Saturation on the narrow-statistics instance (4-bit counters)
        for (int k = 0; k < 20; k++) begin
            sidle(); sbus.FetchValid = 1'b1; sbus.FetchCount = 2'd2; sbus.PairOK = 1'b1;
            tick();
            if (k == 9) check("sat_dual_mid", sbus.DualIssues, 32'd9);
        end
        check("sat_dual", sbus.DualIssues, 32'h0000_000F);
        for (int k = 0; k < 20; k++) begin
            sidle(); sbus.FetchValid = 1'b1; sbus.FetchCount = 2'd1;
            tick();
        end
        check("sat_single", sbus.SingleIssues, 32'h0000_000F);
        check("sat_dual_held", sbus.DualIssues, 32'h0000_000F);
        sidle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 Parameter DEPTH, default 4, meaning instruction-queue entries; power of two, >=4, SHALL be honoured.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset; one clock, reset synchronous and active-low.
REQ-004 FetchValid  in  1  fetch presents an instruction group this cycle.
REQ-005 FetchCount  in  2  group size; 1 = A only, 2 = A then B; 0/3 = no push.
REQ-006 InstrFA, PCPlus4FA, InstrFB, PCPlus4FB  in  32 each  fetched instructions and their PC+4.
REQ-007 FetchReady  out  1  queue accepts a group this cycle.
REQ-008 InstrA, PCPlus4A, InstrB, PCPlus4B  out  32 each  queue head (A) and head+1 (B) presented to both decode slots.
REQ-009 ValidA, ValidB  out  1  slot A / slot B issues this cycle.
REQ-010 PairOK  in  1  combinational dual-issue permission from the hazard checker evaluating the presented A/B pair.
REQ-011 StallD  in  1  decode stall; hold queue, issue nothing.
REQ-012 FlushD  in  1  branch/jump redirect; discard all queued instructions.
REQ-013 DualIssues, SingleIssues  out  32 each  issue-cycle statistics counters.

Function
REQ-014 State machine SHALL have two states: RUN and DRAIN.
REQ-015 Occupancy count (0..DEPTH), head and tail pointers SHALL wrap modulo DEPTH.
REQ-016 FetchReady SHALL be 1 iff state=RUN and DEPTH-count >= 2, computed from the current count (pops this cycle not credited).
REQ-017 Push SHALL occur iff FetchValid & FetchReady & !FlushD; FetchCount=2 writes A at tail, B at tail+1; FetchCount=1 writes A only.
REQ-018 InstrA/PCPlus4A SHALL show the head entry when count>=1, else 0; InstrB/PCPlus4B SHALL show head+1 when count>=2, else 0.
REQ-019 ValidA SHALL be 1 iff state=RUN, count>=1, !StallD, !FlushD (combinational).
REQ-020 ValidB SHALL be 1 iff ValidA, count>=2 and PairOK.
REQ-021 At the clock edge, entries issued (ValidA+ValidB) SHALL be popped; next count = count + pushed - popped, push and pop allowed in the same cycle.
REQ-022 Pushed entries SHALL be visible at the head no earlier than the following cycle (zero-bypass; one-cycle fetch-to-issue latency).
REQ-023 FlushD=1 SHALL, at the edge, clear count and both pointers, drop any push, and move to DRAIN; FlushD has priority over push, pop and StallD.
REQ-024 DRAIN SHALL force FetchReady=0, ValidA=ValidB=0, ignore fetch input, and return to RUN after one cycle; FlushD during DRAIN SHALL hold DRAIN one more cycle.
REQ-025 DualIssues SHALL increment on cycles with ValidB=1; SingleIssues on cycles with ValidA=1 and ValidB=0; both saturate at 0xFFFFFFFF and are not cleared by FlushD.
REQ-026 Queue SHALL never overflow or underflow; FetchCount=2 with only one free slot SHALL be impossible by REQ-016.

Reset
REQ-027 While rst_n=0 at an edge: count=0, pointers=0, state=RUN, counters=0.
REQ-028 After reset: ValidA=ValidB=0, InstrA/B=PCPlus4A/B=0, FetchReady=1.
REQ-029 Reset mid-operation SHALL discard queue contents and override FlushD, StallD and fetch inputs.

Verification
REQ-030 Reset, push pair (0x00221820@PC+4=4, 0x00852020@8), PairOK=1 -> next cycle ValidA=ValidB=1, count returns to 0, DualIssues=1.
REQ-031 Same pair with PairOK=0 -> cycle 1 ValidA only (A issued, SingleIssues=1), cycle 2 old B presented as InstrA with ValidA=1, ValidB=0.
REQ-032 StallD=1 held 3 cycles with fetch pushing pairs, DEPTH=4 -> queue fills to 4, FetchReady=0, ValidA=0, counters unchanged; StallD release resumes issue in order.
REQ-033 FlushD=1 with count=3 and simultaneous push -> next cycle count=0, state DRAIN, FetchReady=0; cycle after, RUN, FetchReady=1.
REQ-034 Continuous pushes of FetchCount=1 with PairOK toggling across pointer wrap (>=10 instructions) -> issue order equals fetch order, no loss or duplication.
REQ-035 Force DualIssues near 0xFFFFFFFF via repeated dual issue (or backdoor preload) -> counter holds at 0xFFFFFFFF.
